// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing constants and types for the VGA timing generator.
//   DEF_*            default 640x480@60 geometry (pixels / lines)
//   H_TOTAL/V_TOTAL  derived totals for the default geometry
//   HS_*/VS_*        sync window for the default geometry, START inclusive, END exclusive
//   coord_t          10-bit raster coordinate used for DrawX/DrawY
package vga_timing_pkg;
  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_SYNC_DELAY = 2;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the generator to the pixel
// mappers and the DAC/HDMI encoder.
//   master: driven by vga_timing_gen
//   slave : consumers (mappers, encoder)
//   DrawX/DrawY  raster position; blank 1 = visible pixel
//   hs/vs        active-low syncs
//   line_start/frame_start/vblank_start  one-cycle strobes
interface vga_timing_gen_if;
  vga_timing_pkg::coord_t DrawX;
  vga_timing_pkg::coord_t DrawY;
  logic blank;
  logic hs;
  logic vs;
  logic line_start;
  logic frame_start;
  logic vblank_start;

  modport master (output DrawX, DrawY, blank, hs, vs, line_start, frame_start, vblank_start);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, vblank_start);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   clk_i     clock
//   reset_i   synchronous active-high reset
//   inc_i     advance the count this cycle
//   count_o   registered count (0..TOTAL-1)
//   next_o    value count_o takes on the next edge
//   wrap_o    count_o is at TOTAL-1 and advances to 0 on the next edge
//   sync_n_o  active-low sync decode of next_o
//   active_o  next_o lies in the visible region
// Decodes are from next_o so the parent can register them alongside count_o.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   inc_i,
  output coord_t count_o,
  output coord_t next_o,
  output logic   wrap_o,
  output logic   sync_n_o,
  output logic   active_o
);
  coord_t cnt_q, cnt_d;
  logic   run_q;

  // run_q is low for the first edge after reset so the counter presents 0
  // on that edge instead of 1; the raster restarts exactly at (0,0).
  always_comb begin
    wrap_o = run_q && inc_i && (cnt_q == coord_t'(TOTAL - 1));
    cnt_d  = cnt_q;
    if (!run_q)      cnt_d = '0;
    else if (wrap_o) cnt_d = '0;
    else if (inc_i)  cnt_d = cnt_q + coord_t'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= 1'b1;
    end
  end

  assign count_o  = cnt_q;
  assign next_o   = cnt_d;
  assign sync_n_o = !((cnt_d >= coord_t'(SYNC_START)) && (cnt_d < coord_t'(SYNC_END)));
  assign active_o = cnt_d < coord_t'(ACTIVE);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the 25 MHz pixel clock.
//   vga_clk  pixel clock
//   reset    synchronous active-high reset
//   vga      vga_timing_gen_if.master: DrawX, DrawY, blank, hs, vs,
//            line_start, frame_start, vblank_start (all registered)
// Optional: define VGA_SYNC_DELAY_EN to delay hs/vs by SYNC_DELAY extra
// cycles (stages reset to 1) so sync lines up with colour emerging from a
// 2-cycle mapper. Position, blank and strobes are never delayed.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);
  localparam int HTOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VTOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HSS  = H_VISIBLE + H_FRONT;
  localparam int VSS  = V_VISIBLE + V_FRONT;

`ifdef VGA_SYNC_DELAY_EN
  localparam bit DLY_EN = 1'b1;
`else
  localparam bit DLY_EN = 1'b0;
`endif
  localparam int DLY = DLY_EN ? SYNC_DELAY : 0;

  coord_t h_cnt, h_next, v_cnt, v_next;
  logic   h_wrap, h_sync_n, h_act;
  logic   v_wrap, v_sync_n, v_act;

  vga_axis_counter #(
    .TOTAL(HTOT), .ACTIVE(H_VISIBLE), .SYNC_START(HSS), .SYNC_END(HSS + H_SYNC)
  ) u_h (
    .clk_i(vga_clk), .reset_i(reset), .inc_i(1'b1),
    .count_o(h_cnt), .next_o(h_next), .wrap_o(h_wrap),
    .sync_n_o(h_sync_n), .active_o(h_act)
  );

  // vertical advances on the same edge the horizontal counter wraps
  vga_axis_counter #(
    .TOTAL(VTOT), .ACTIVE(V_VISIBLE), .SYNC_START(VSS), .SYNC_END(VSS + V_SYNC)
  ) u_v (
    .clk_i(vga_clk), .reset_i(reset), .inc_i(h_wrap),
    .count_o(v_cnt), .next_o(v_next), .wrap_o(v_wrap),
    .sync_n_o(v_sync_n), .active_o(v_act)
  );

  // restart: first edge after reset, where both counters present 0 without wrapping
  logic restart, line_start_d, frame_start_d, vblank_start_d;
  always_comb begin
    restart        = (h_next == '0) && !h_wrap;
    line_start_d   = h_wrap || restart;
    frame_start_d  = v_wrap || restart;
    vblank_start_d = h_wrap && (v_next == coord_t'(V_VISIBLE));
  end

  logic blank_q, hs_q, vs_q, line_start_q, frame_start_q, vblank_start_q;
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_q        <= 1'b0;
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      blank_q        <= h_act && v_act;
      hs_q           <= h_sync_n;
      vs_q           <= v_sync_n;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign vga.DrawX        = h_cnt;
  assign vga.DrawY        = v_cnt;
  assign vga.blank        = blank_q;
  assign vga.line_start   = line_start_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.vblank_start = vblank_start_q;

  generate
    if (DLY == 0) begin : g_nodly
      assign vga.hs = hs_q;
      assign vga.vs = vs_q;
    end else begin : g_dly
      logic [DLY-1:0] hs_pipe_q, vs_pipe_q;
      // bit 0 takes the fresh decode; the MSB of the concat falls off
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_pipe_q <= '1;
          vs_pipe_q <= '1;
        end else begin
          hs_pipe_q <= DLY'({hs_pipe_q, hs_q});
          vs_pipe_q <= DLY'({vs_pipe_q, vs_q});
        end
      end
      assign vga.hs = hs_pipe_q[DLY-1];
      assign vga.vs = vs_pipe_q[DLY-1];
    end
  endgenerate
endmodule
